// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-requester arbiter for the memory bus.
// Optional macro ARB_LOCK_EN adds r0_lock/r1_lock for locked re-grants.
module mem_bus_arbiter #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 16,
  parameter logic [AW-1:0] BTN_ADDR = 16'h2000
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef ARB_LOCK_EN
  input  logic          r0_lock,
  input  logic          r1_lock,
`endif
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_address,
  output logic          mem_load,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out,
  output logic          wr_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd0_q,   rd0_d;
  logic [DW-1:0] rd1_q,   rd1_d;
`ifdef ARB_LOCK_EN
  logic          lock_hold_q, lock_hold_d;
`endif

  logic gnt_vld;
  logic gnt_id;
  logic is_btn;

  // Pick the winner among current requests (round-robin on ties).
  always_comb begin
    gnt_vld = r0_req | r1_req;
    gnt_id  = 1'b0;
    unique case (1'b1)
      r0_req & r1_req:  gnt_id = ~last_q;
      r1_req & ~r0_req: gnt_id = 1'b1;
      default:          gnt_id = 1'b0;
    endcase
`ifdef ARB_LOCK_EN
    if (lock_hold_q) begin
      gnt_id  = owner_q;
      gnt_vld = owner_q ? r1_req : r0_req;
    end
`endif
  end

  assign is_btn = (addr_q == BTN_ADDR);

  // Sequencer next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifdef ARB_LOCK_EN
    lock_hold_d = lock_hold_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_ADDR;
          owner_d = gnt_id;
          last_d  = gnt_id;
          we_d    = gnt_id ? r1_we    : r0_we;
          addr_d  = gnt_id ? r1_addr  : r0_addr;
          wdata_d = gnt_id ? r1_wdata : r0_wdata;
        end
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_ACK;
        if (owner_q) rd1_d = mem_out;
        else         rd0_d = mem_out;
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef ARB_LOCK_EN
        lock_hold_d = owner_q ? r1_lock : r0_lock;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock flag that pins the next grant to the previous owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_hold_q <= 1'b0;
    else        lock_hold_q <= lock_hold_d;
  end
`endif

  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_load    = (state_q == S_ADDR) & we_q & ~is_btn;
  assign wr_err      = (state_q == S_ADDR) & we_q &  is_btn;
  assign busy        = (state_q != S_IDLE);
  assign r0_ack      = (state_q == S_ACK) & ~owner_q;
  assign r1_ack      = (state_q == S_ACK) &  owner_q;
  assign r0_rdata    = rd0_q;
  assign r1_rdata    = rd1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus ack scoreboard for mem_bus_arbiter.
// Define ARB_LOCK_EN for both files to run the lock sequence.
module tb_mem_bus_arbiter;

  localparam logic [15:0] BTN_VAL = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req, r0_we, r0_ack;
  logic [15:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_ack;
  logic [15:0] r1_addr, r1_wdata, r1_rdata;
  logic [15:0] mem_address, mem_in;
  logic [15:0] mem_out = 16'h0;
  logic        mem_load, wr_err, busy;
`ifdef ARB_LOCK_EN
  logic        r0_lock, r1_lock;
`endif

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ARB_LOCK_EN
    .r0_lock(r0_lock),
    .r1_lock(r1_lock),
`endif
    .r0_req(r0_req),
    .r0_we(r0_we),
    .r0_addr(r0_addr),
    .r0_wdata(r0_wdata),
    .r0_ack(r0_ack),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req),
    .r1_we(r1_we),
    .r1_addr(r1_addr),
    .r1_wdata(r1_wdata),
    .r1_ack(r1_ack),
    .r1_rdata(r1_rdata),
    .mem_address(mem_address),
    .mem_load(mem_load),
    .mem_in(mem_in),
    .mem_out(mem_out),
    .wr_err(wr_err),
    .busy(busy)
  );

  // Memory model: RAM below 0x2000, button and LED registers above.
  logic [15:0] ram [0:8191];
  logic [15:0] led_q = 16'h0;
  always @(posedge clk) begin
    if (mem_load) begin
      if (!mem_address[13]) ram[mem_address[12:0]] <= mem_in;
      else if (mem_address == 16'h2001) led_q <= mem_in;
    end
    if (mem_address == 16'h2000) mem_out <= BTN_VAL;
    else if (mem_address == 16'h2001) mem_out <= led_q;
    else if (!mem_address[13]) mem_out <= ram[mem_address[12:0]];
    else mem_out <= 16'h0;
  end

  typedef struct {
    bit          id;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    bit          id;
    logic [15:0] rdata;
    bit          chk;
  } sb_t;

  vec_t vecs [10];
  sb_t  sbq [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit id, bit req, bit we,
                       logic [15:0] a, logic [15:0] d);
    if (id) begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end else begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end
  endtask

  task automatic push(bit id, logic [15:0] rd, bit chk);
    sb_t e;
    e.id = id; e.rdata = rd; e.chk = chk;
    sbq.push_back(e);
  endtask

  task automatic on_ack();
    sb_t e;
    check("ack_both", {31'b0, r0_ack & r1_ack}, 0);
    if (sbq.size() == 0) begin
      check("ack_unexpected", 1, 0);
      return;
    end
    e = sbq.pop_front();
    check("ack_owner", {31'b0, r1_ack}, {31'b0, e.id});
    if (e.chk)
      check("rdata", e.id ? r1_rdata : r0_rdata, e.rdata);
  endtask

  task automatic run_txn(vec_t v);
    int cyc = 0;
    int loads = 0;
    int errs = 0;
    bit got = 0;
    bit btn;
    btn = (v.addr == 16'h2000);
    @(negedge clk);
    drive(v.id, 1'b1, v.we, v.addr, v.wdata);
    push(v.id, v.exp, !v.we);
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_addr", {31'b0, busy}, 1);
      if (mem_load) begin
        loads++;
        check("load_addr", mem_address, v.addr);
        check("load_data", mem_in, v.wdata);
      end
      if (wr_err) errs++;
      if (r0_ack || r1_ack) begin
        got = 1;
        on_ack();
        drive(v.id, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    if (!got) begin
      sbq.delete();
      drive(v.id, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    check("ack_latency", cyc, 3);
    check("load_cycles", loads, (v.we && !btn) ? 1 : 0);
    check("wr_err_pulses", errs, (v.we && btn) ? 1 : 0);
  endtask

  int n, cyc, last_ack, acks;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 16'h2000, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h2000, 16'h0000, BTN_VAL};
    vecs[4] = '{1'b0, 1'b1, 16'h2001, 16'h0001, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 16'h0001};
    vecs[6] = '{1'b1, 1'b1, 16'h1FFF, 16'hCAFE, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 16'h1FFF, 16'h0000, 16'hCAFE};
    vecs[8] = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000};
    vecs[9] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF};

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef ARB_LOCK_EN
    r0_lock = 1'b0;
    r1_lock = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr_in", {mem_address, mem_in}, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    check("rst_ctrl", {27'b0, mem_load, r0_ack, r1_ack, wr_err, busy}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset during WAIT of an r1 read: transaction is lost.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    repeat (2) @(negedge clk);
    check("busy_wait", {31'b0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {28'b0, busy, mem_load, r0_ack, r1_ack}, 0);
    check("rst_async_rdata", r1_rdata, 0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) acks++;
    end
    check("no_ack_after_rst", acks, 0);

    // Both requesting continuously: r0 first, then strict alternation.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h2001, 16'h0);
    push(1'b0, 16'h1234, 1'b1);
    push(1'b1, 16'h0001, 1'b1);
    push(1'b0, 16'h1234, 1'b1);
    push(1'b1, 16'h0001, 1'b1);
    n = 0; cyc = 0; last_ack = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack || r1_ack) begin
        on_ack();
        if (n == 0) check("first_tie_lat", cyc, 3);
        else check("ack_spacing", cyc - last_ack, 4);
        last_ack = cyc;
        n++;
        if (n == 4) begin
          drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
          drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
    end
    check("fair_acks", n, 4);
    sbq.delete();

`ifdef ARB_LOCK_EN
    // Locked read then unlocked write by r0 beat a waiting r1.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    r0_lock = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    push(1'b0, 16'h0, 1'b0);
    push(1'b0, 16'h0, 1'b0);
    push(1'b1, 16'h1234, 1'b1);
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack || r1_ack) begin
        on_ack();
        n++;
        if (n == 1) begin
          @(negedge clk);
          cyc++;
          drive(1'b0, 1'b1, 1'b1, 16'h0010, 16'h5A5A);
          r0_lock = 1'b0;
        end else if (n == 2) begin
          drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end else begin
          drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
      end
    end
    check("lock_acks", n, 3);
    sbq.delete();
    begin
      vec_t v;
      v = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5A5A};
      run_txn(v);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
